// File: rtl/eeprom_arb.sv
// Two-port round-robin arbiter/sequencer in front of the EEPROM_WR serial engine.
// Optional ACK timeout is compiled in with `define EEPROM_ARB_TIMEOUT_EN.
module eeprom_arb #(
  parameter int ADDR_W  = 11,
  parameter int DATA_W  = 8,
  parameter int GAP_CYC = 16,
  parameter int TO_CYC  = 4096
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req0_i,
  input  logic              we0_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [DATA_W-1:0] wdata0_i,
  output logic              gnt0_o,
  output logic              done0_o,
  input  logic              req1_i,
  input  logic              we1_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] wdata1_i,
  output logic              gnt1_o,
  output logic              done1_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              err_o,
  output logic              wr_o,
  output logic              rd_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] data_o,
  output logic              data_oe_o,
  input  logic [DATA_W-1:0] data_i,
  input  logic              ack_i
);

  localparam int GapW = $clog2(GAP_CYC + 1);
  localparam logic [GapW-1:0] GapLoad = GapW'(GAP_CYC - 1);

  if (GAP_CYC < 1 || TO_CYC < 2) begin : g_bad_params
    $error("eeprom_arb: GAP_CYC must be >= 1 and TO_CYC >= 2");
  end

  typedef enum logic [1:0] {Idle, Issue, WaitAck, Gap} state_e;

  state_e            state_q;
  logic [GapW-1:0]   gap_q;
  logic              port_q, we_q, last_q;
  logic              gnt0_q, gnt1_q, done0_q, done1_q, err_q, wr_q, rd_q, oe_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q, rdata_q;
  logic              pick1;

`ifdef EEPROM_ARB_TIMEOUT_EN
  localparam int ToW = $clog2(TO_CYC);
  localparam logic [ToW-1:0] ToMax = ToW'(TO_CYC - 1);
  logic [ToW-1:0] to_q;
`endif

  // On a tie the port that was not granted last wins; last_q resets to 1 so port0 wins first.
  assign pick1 = req1_i & (~req0_i | ~last_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= Idle;
      gap_q   <= '0;
      port_q  <= 1'b0;
      we_q    <= 1'b0;
      last_q  <= 1'b1;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      err_q   <= 1'b0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      oe_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      rdata_q <= '0;
`ifdef EEPROM_ARB_TIMEOUT_EN
      to_q    <= '0;
`endif
    end else begin
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      err_q   <= 1'b0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      unique case (state_q)
        Idle: begin
          if (req0_i || req1_i) begin
            port_q  <= pick1;
            last_q  <= pick1;
            gnt0_q  <= ~pick1;
            gnt1_q  <= pick1;
            we_q    <= pick1 ? we1_i : we0_i;
            oe_q    <= pick1 ? we1_i : we0_i;
            addr_q  <= pick1 ? addr1_i : addr0_i;
            data_q  <= pick1 ? wdata1_i : wdata0_i;
            state_q <= Issue;
          end
        end
        Issue: begin
          wr_q    <= we_q;
          rd_q    <= ~we_q;
`ifdef EEPROM_ARB_TIMEOUT_EN
          to_q    <= '0;
`endif
          state_q <= WaitAck;
        end
        WaitAck: begin
          // ACK is checked first so an ACK on the expiry cycle completes normally.
          if (ack_i) begin
            done0_q <= ~port_q;
            done1_q <= port_q;
            oe_q    <= 1'b0;
            gap_q   <= GapLoad;
            state_q <= Gap;
            if (!we_q) rdata_q <= data_i;
          end
`ifdef EEPROM_ARB_TIMEOUT_EN
          else if (to_q == ToMax) begin
            done0_q <= ~port_q;
            done1_q <= port_q;
            err_q   <= 1'b1;
            oe_q    <= 1'b0;
            gap_q   <= GapLoad;
            state_q <= Gap;
            if (!we_q) rdata_q <= '1;
          end else begin
            to_q <= to_q + 1'b1;
          end
`endif
        end
        Gap: begin
          if (gap_q == '0) state_q <= Idle;
          else             gap_q   <= gap_q - 1'b1;
        end
        default: state_q <= Idle;
      endcase
    end
  end

  assign gnt0_o    = gnt0_q;
  assign gnt1_o    = gnt1_q;
  assign done0_o   = done0_q;
  assign done1_o   = done1_q;
  assign err_o     = err_q;
  assign wr_o      = wr_q;
  assign rd_o      = rd_q;
  assign addr_o    = addr_q;
  assign data_o    = data_q;
  assign data_oe_o = oe_q;
  assign rdata_o   = rdata_q;

endmodule

// File: tb/tb_eeprom_arb.sv
// Self-checking bench for eeprom_arb: a transaction-level model predicts every output each cycle,
// while directed sequences pin hand-computed values. Honours EEPROM_ARB_TIMEOUT_EN if defined.
module tb_eeprom_arb;
  localparam int ADDR_W  = 11;
  localparam int DATA_W  = 8;
  localparam int GAP_CYC = 16;
  localparam int TO_CYC  = 4096;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0, ack = 1'b0;
  logic [ADDR_W-1:0] addr0 = '0, addr1 = '0;
  logic [DATA_W-1:0] wdata0 = '0, wdata1 = '0, dataIn = '0;
  logic gnt0, gnt1, done0, done1, err, wr, rd, dataOe;
  logic [ADDR_W-1:0] addrOut;
  logic [DATA_W-1:0] dataOut, rdata;

  int checks = 0;
  int errors = 0;

  eeprom_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .GAP_CYC(GAP_CYC), .TO_CYC(TO_CYC)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req0_i(req0), .we0_i(we0), .addr0_i(addr0), .wdata0_i(wdata0), .gnt0_o(gnt0), .done0_o(done0),
    .req1_i(req1), .we1_i(we1), .addr1_i(addr1), .wdata1_i(wdata1), .gnt1_o(gnt1), .done1_o(done1),
    .rdata_o(rdata), .err_o(err), .wr_o(wr), .rd_o(rd), .addr_o(addrOut), .data_o(dataOut),
    .data_oe_o(dataOe), .data_i(dataIn), .ack_i(ack)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Model state: the transaction in flight is described by its grant edge number; every
  // output follows from edge arithmetic relative to that grant and to the last completion.
  int  edgeN = 0, grantEdge = 0, freeEdge = 0, lastPort = 1, mPort = 0, winner = 0;
  bit  mBusy = 0, mWe = 0;
  bit  eGnt0 = 0, eGnt1 = 0, eDone0 = 0, eDone1 = 0, eErr = 0, eWr = 0, eRd = 0, eOe = 0;
  logic [ADDR_W-1:0] eAddr = '0;
  logic [DATA_W-1:0] eDataO = '0, eRdata = '0;

  task automatic modelFinish(input bit timedOut);
    eDone0 = (mPort == 0);
    eDone1 = (mPort == 1);
    eErr   = timedOut;
    if (!mWe) eRdata = timedOut ? '1 : dataIn;
    mBusy    = 0;
    freeEdge = edgeN + GAP_CYC + 1;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mBusy = 0; lastPort = 1; freeEdge = 0;
      eGnt0 = 0; eGnt1 = 0; eDone0 = 0; eDone1 = 0; eErr = 0; eWr = 0; eRd = 0; eOe = 0;
      eAddr = '0; eDataO = '0; eRdata = '0;
    end else begin
      edgeN++;
      eGnt0 = 0; eGnt1 = 0; eDone0 = 0; eDone1 = 0; eErr = 0; eWr = 0; eRd = 0;
      if (mBusy) begin
        if (edgeN == grantEdge + 1) begin
          eWr = mWe;
          eRd = !mWe;
        end else if (edgeN >= grantEdge + 2 && ack) begin
          modelFinish(1'b0);
        end
`ifdef EEPROM_ARB_TIMEOUT_EN
        else if (edgeN == grantEdge + 1 + TO_CYC) begin
          modelFinish(1'b1);
        end
`endif
      end else if (edgeN >= freeEdge && (req0 || req1)) begin
        winner    = (req0 && req1) ? 1 - lastPort : (req1 ? 1 : 0);
        lastPort  = winner;
        mPort     = winner;
        mBusy     = 1;
        grantEdge = edgeN;
        mWe       = (winner == 1) ? we1 : we0;
        eAddr     = (winner == 1) ? addr1 : addr0;
        eDataO    = (winner == 1) ? wdata1 : wdata0;
        eGnt0     = (winner == 0);
        eGnt1     = (winner == 1);
      end
      eOe = mBusy && mWe;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("GNT0", gnt0, eGnt0);
      checkOutput("GNT1", gnt1, eGnt1);
      checkOutput("DONE0", done0, eDone0);
      checkOutput("DONE1", done1, eDone1);
      checkOutput("ERR", err, eErr);
      checkOutput("WR", wr, eWr);
      checkOutput("RD", rd, eRd);
      checkOutput("DATA_OE", dataOe, eOe);
      checkOutput("ADDR", addrOut, eAddr);
      checkOutput("DATA_O", dataOut, eDataO);
      checkOutput("RDATA", rdata, eRdata);
    end
  end

  task automatic waitGnt(input int bound, output int port);
    port = -1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (gnt0) begin port = 0; break; end
      if (gnt1) begin port = 1; break; end
    end
    if (port < 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL grant_wait actual=none required=grant_within_%0d", bound);
    end
  endtask

  task automatic applyStimulus(input int port, input bit we, input logic [ADDR_W-1:0] a,
                               input logic [DATA_W-1:0] wd);
    if (port == 0) begin req0 = 1; we0 = we; addr0 = a; wdata0 = wd; end
    else           begin req1 = 1; we1 = we; addr1 = a; wdata1 = wd; end
  endtask

  task automatic pulseAck(input logic [DATA_W-1:0] d);
    ack = 1; dataIn = d;
    @(negedge clk);
    ack = 0; dataIn = '0;
  endtask

  int p, cnt;
  int seq[4];
  bit sawDone;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (2) @(negedge clk);
    checkOutput("RST_GNT0", gnt0, 0);
    checkOutput("RST_WR", wr, 0);
    checkOutput("RST_RD", rd, 0);
    checkOutput("RST_OE", dataOe, 0);
    checkOutput("RST_ADDR", addrOut, 0);
    checkOutput("RST_RDATA", rdata, 0);
    rst_n = 1;
    @(negedge clk);

    // Single write from port0.
    applyStimulus(0, 1, 11'h123, 8'hA5);
    waitGnt(10, p);
    req0 = 0;
    checkOutput("W_GNT_PORT", p, 0);
    checkOutput("W_ADDR", addrOut, 11'h123);
    checkOutput("W_DATA_O", dataOut, 8'hA5);
    checkOutput("W_OE", dataOe, 1);
    @(negedge clk);
    checkOutput("W_WR", wr, 1);
    repeat (2) @(negedge clk);
    pulseAck(8'h00);
    checkOutput("W_DONE0", done0, 1);
    checkOutput("W_OE_OFF", dataOe, 0);

    // Request right after DONE must wait out the gap.
    applyStimulus(0, 0, 11'h055, 8'h00);
    cnt = 0;
    while (!gnt0 && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    req0 = 0;
    checkOutput("GAP_WAIT", cnt, GAP_CYC + 1);
    repeat (2) @(negedge clk);
    pulseAck(8'h99);
    checkOutput("GAP_RDATA", rdata, 8'h99);

    // Single read from port1, with a stray ACK during the launch cycle that must be ignored.
    repeat (GAP_CYC + 2) @(negedge clk);
    applyStimulus(1, 0, 11'h7FF, 8'h00);
    waitGnt(10, p);
    req1 = 0;
    checkOutput("R_GNT_PORT", p, 1);
    ack = 1;
    @(negedge clk);
    ack = 0;
    checkOutput("R_RD", rd, 1);
    checkOutput("R_NO_EARLY_DONE", done1, 0);
    @(negedge clk);
    pulseAck(8'h3C);
    checkOutput("R_DONE1", done1, 1);
    checkOutput("R_RDATA", rdata, 8'h3C);

    // Stray ACKs while idle produce nothing.
    repeat (GAP_CYC + 2) @(negedge clk);
    ack = 1;
    repeat (2) @(negedge clk);
    ack = 0;

    // Round robin after a fresh reset with both requests held.
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    applyStimulus(0, 1, 11'h010, 8'h11);
    applyStimulus(1, 0, 11'h020, 8'h00);
    for (int i = 0; i < 4; i++) begin
      waitGnt(GAP_CYC + 10, seq[i]);
      repeat (2) @(negedge clk);
      pulseAck(8'h5A);
    end
    req0 = 0;
    req1 = 0;
    for (int i = 0; i < 4; i++) checkOutput($sformatf("RR_ORDER_%0d", i), seq[i], i % 2);

    // Reset in the middle of a read abandons it silently.
    repeat (GAP_CYC + 2) @(negedge clk);
    applyStimulus(0, 0, 11'h0AA, 8'h00);
    waitGnt(10, p);
    req0 = 0;
    repeat (3) @(negedge clk);
    rst_n = 0;
    #1;
    checkOutput("MID_RST_RD", rd, 0);
    checkOutput("MID_RST_DONE0", done0, 0);
    checkOutput("MID_RST_ADDR", addrOut, 0);
    checkOutput("MID_RST_RDATA", rdata, 0);
    @(negedge clk);
    rst_n = 1;
    applyStimulus(0, 1, 11'h0BB, 8'h77);
    waitGnt(10, p);
    req0 = 0;
    checkOutput("POST_RST_PORT", p, 0);
    repeat (2) @(negedge clk);
    pulseAck(8'h00);

    // A read that is never acknowledged.
    repeat (GAP_CYC + 2) @(negedge clk);
    applyStimulus(0, 0, 11'h100, 8'h00);
    waitGnt(10, p);
    req0 = 0;
    sawDone = 0;
    cnt = 0;
    for (int i = 0; i < TO_CYC + 50; i++) begin
      @(negedge clk);
      cnt++;
      if (done0) begin sawDone = 1; break; end
    end
`ifdef EEPROM_ARB_TIMEOUT_EN
    checkOutput("TO_DONE_SEEN", sawDone, 1);
    checkOutput("TO_LATENCY", cnt, TO_CYC + 1);
    checkOutput("TO_ERR", err, 1);
    checkOutput("TO_RDATA", rdata, 8'hFF);
`else
    checkOutput("NO_TO_DONE", sawDone, 0);
    pulseAck(8'hC3);
    checkOutput("LATE_ACK_DONE0", done0, 1);
    checkOutput("LATE_ACK_RDATA", rdata, 8'hC3);
`endif
    repeat (GAP_CYC + 4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
